mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers of the pipelined CPU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and runs multiply/divide iteratively over 32 cycles. It stalls the pipeline while an operation is in flight, and presents HI/LO to the register-file write-data selection for MFHI/MFLO. HIMUX/LOMUX-style selection (rs_value vs. result) is internal.

## Interface
- WIDTH, 32, operand/register width; only 32 is supported.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  an MDU instruction in EX is valid this cycle.
- op  in  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x reserved, ignored.
- rs_value  in  WIDTH  forwarded rs operand; dividend, multiplicand, or MTHI/MTLO source.
- rt_value  in  WIDTH  forwarded rt operand; divisor or multiplier.
- rd_req  in  1  MFHI/MFLO in EX wants HI/LO this cycle.
- flush  in  1  abort any in-flight operation (exception/ERET).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  operation in CALC or WB.
- done  out  1  one-cycle pulse in the WB cycle.
- stall  out  1  combinational: busy & (start | rd_req) & ~flush.

## Operation
- FSM states:
  - IDLE: on start with op 0xx, latch operand magnitudes, signs and op; load count=31; go to CALC.
  - CALC: perform one shift-add (mult) or restoring-subtract (div) step per cycle; decrement count; at count==0 go to WB.
  - WB: apply sign fix-up, write HI/LO, pulse done; go to IDLE.
- MTHI/MTLO are legal only in IDLE. hi (resp. lo) is set to rs_value at the edge. They are single-cycle, cause no state change, and done stays 0.
- While busy, start and rd_req are not accepted; stall=1 until IDLE. The stalled instruction is then re-presented and accepted in the first IDLE cycle.
- Mult: 64-bit product of magnitudes; for MULT, negate (two's complement) when operand signs differ. hi=product[63:32], lo=product[31:0].
- Div: lo=quotient, hi=remainder.
  - For DIV, the quotient is negative iff operand signs differ; the remainder takes the dividend's sign.
  - Divide by zero (both DIV and DIVU): lo=32'hFFFFFFFF, hi=rs_value as latched. This is detected at start, but the full 32 cycles still run.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (two's-complement wrap).
  - Magnitude of 0x80000000 is 0x80000000 unsigned; no special case.
- flush in CALC/WB: next state IDLE; HI/LO unchanged; no done. flush in IDLE: no effect, and a start or MTHI/MTLO in the same cycle is discarded.
- Reserved op with start: ignored, no state change.

## Timing
- Reset (async): state IDLE, hi=0, lo=0, busy=0, done=0, count=0. stall=0 follows from busy=0.
- Operation accepted at edge E0 → CALC occupies cycles 1–32 → WB in cycle 33 (done=1) → HI/LO visible from cycle 34.
- Total latency: 34 cycles from start to readable result. busy=1 during cycles 1–33.
- start and rd_req are sampled each cycle; stall is a combinational output with no register.
- rst asserted mid-operation: immediate return to reset values regardless of the clock.

## Structure
- Package mdu_pkg holds:
  - op encodings (MDU_MULT…MDU_MTLO);
  - state enum {IDLE, CALC, WB};
  - ITER=32;
  - DIV0_Q=32'hFFFFFFFF.
- One sub-module, mdu_iter_step: combinational single-iteration datapath. It takes the 64-bit accumulator, the operand magnitude and an is_div flag, and returns the next accumulator (shift-add or restoring subtract). The sequencer holds all registers, the FSM and the counter.

## Test plan
- MULT rs=0xFFFFFFFE (−2), rt=3 → after 34 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once in cycle 33; busy high for 33 cycles.
- DIVU rs=100, rt=7 → lo=14, hi=2. DIV rs=−7, rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- DIVU rs=0x1234, rt=0 → lo=0xFFFFFFFF, hi=0x1234 after full latency.
- rd_req asserted at cycle 5 of a MULTU 0xFFFFFFFF×0xFFFFFFFF → stall=1 through cycle 33, 0 in cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
- MTHI 0xAAAA5555 then MTLO 0x1 on consecutive cycles → hi/lo updated after each edge, busy=0 throughout. MTHI during busy → stall=1, hi unchanged until the re-presented MTHI is accepted in IDLE.
- flush at cycle 10 of a DIV → IDLE next cycle, hi/lo keep prior values, no done. rst pulse at cycle 20 of a MULT → hi=lo=0, busy=0 immediately.

Source files
------------

// File: rtl/mdu_sequencer_pkg.sv
// Shared encodings, FSM states and constants for the multiply/divide sequencer.
package mdu_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    localparam logic [31:0] DIV0_Q = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        WB   = 2'd2
    } mdu_state_e;

    // Magnitude of a 32-bit operand; 0x80000000 maps to itself as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// EX-stage <-> MDU bundle. Commands are single-cycle strobes; while busy the MDU
// does not accept start/rd_req and raises stall until the instruction can be re-presented.
interface mdu_sequencer_if;
    import mdu_pkg::*;

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_value;
    logic [WIDTH-1:0] rt_value;
    logic             rd_req;
    logic             flush;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;
    mdu_state_e       state;

    modport master (
        output start, op, rs_value, rt_value, rd_req, flush,
        input  hi, lo, busy, done, stall, state
    );

    modport slave (
        input  start, op, rs_value, rt_value, rd_req, flush,
        output hi, lo, busy, done, stall, state
    );

endinterface

// File: rtl/mdu_sequencer_iter_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
module mdu_iter_step (
    input  logic [63:0] acc,
    input  logic [31:0] mag,
    input  logic        is_div,
    output logic [63:0] acc_next
);

    logic [32:0] sum;
    logic [32:0] upper;
    logic [31:0] diff;
    logic        fits;

    // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        sum      = {1'b0, acc[63:32]} + {1'b0, mag};
        upper    = acc[63:31];
        fits     = (upper >= {1'b0, mag});
        diff     = upper[31:0] - mag;
        acc_next = acc;
        if (is_div) begin
            if (fits) acc_next = {diff, acc[30:0], 1'b1};
            else      acc_next = {upper[31:0], acc[30:0], 1'b0};
        end else begin
            if (acc[0]) acc_next = {sum, acc[31:1]};
            else        acc_next = {1'b0, acc[63:1]};
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// HI/LO owner: accepts MULT/DIV/MTHI/MTLO from EX, iterates 32 cycles, stalls the pipe while busy.
module mdu_sequencer
    import mdu_pkg::*;
(
    input logic          clk,
    input logic          rst,
    mdu_sequencer_if.slave bus
);

    mdu_state_e  state_q;
    logic [4:0]  count_q;
    logic [63:0] acc_q;
    logic [31:0] mag_q;
    logic        is_div_q;
    logic        neg_q;
    logic        rem_neg_q;
    logic        div0_q;
    logic [31:0] rs_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;

    logic        accept;
    logic        is_md;
    logic        sgn;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] acc_next;
    logic [63:0] prod;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign accept = bus.start & ~bus.flush & (state_q == IDLE);
    assign is_md  = ~bus.op[2];
    assign sgn    = (bus.op == MDU_MULT) | (bus.op == MDU_DIV);
    assign a_mag  = mag32(bus.rs_value, sgn);
    assign b_mag  = mag32(bus.rt_value, sgn);

    mdu_iter_step u_step (
        .acc      (acc_q),
        .mag      (mag_q),
        .is_div   (is_div_q),
        .acc_next (acc_next)
    );

    // Sign fix-up for the write-back cycle.
    always_comb begin
        prod   = neg_q ? (~acc_q + 64'd1) : acc_q;
        q_fix  = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        r_fix  = rem_neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div_q) begin
            res_hi = div0_q ? rs_q : r_fix;
            res_lo = div0_q ? DIV0_Q : q_fix;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= 5'd0;
            acc_q     <= 64'd0;
            mag_q     <= 32'd0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            rs_q      <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept && is_md) begin
                        state_q   <= CALC;
                        busy_q    <= 1'b1;
                        count_q   <= 5'(ITER - 1);
                        is_div_q  <= bus.op[1];
                        neg_q     <= sgn & (bus.rs_value[31] ^ bus.rt_value[31]);
                        rem_neg_q <= sgn & bus.rs_value[31];
                        div0_q    <= bus.op[1] & (bus.rt_value == 32'd0);
                        rs_q      <= bus.rs_value;
                        mag_q     <= bus.op[1] ? b_mag : a_mag;
                        acc_q     <= bus.op[1] ? {32'd0, a_mag} : {32'd0, b_mag};
                    end else if (accept && bus.op == MDU_MTHI) begin
                        hi_q <= bus.rs_value;
                    end else if (accept && bus.op == MDU_MTLO) begin
                        lo_q <= bus.rs_value;
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_next;
                        if (count_q == 5'd0) begin
                            state_q <= WB;
                            done_q  <= 1'b1;
                        end else begin
                            count_q <= count_q - 5'd1;
                        end
                    end
                end
                WB: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!bus.flush) begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy_q;
    // A flush landing in the WB cycle cancels the result, so the pulse is masked too.
    assign bus.done  = done_q & ~bus.flush;
    assign bus.stall = busy_q & (bus.start | bus.rd_req) & ~bus.flush;
    assign bus.state = state_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: vector table of full operations plus stall/flush/reset sequences.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst;

    mdu_sequencer_if bus ();

    mdu_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[13];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_op(input int idx, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int busy_cnt, done_cnt, done_cyc;
        logic fin;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.rs_value = a; bus.rt_value = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_cyc = 0; fin = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin done_cnt++; done_cyc = k; end
            if (!bus.busy) begin fin = 1'b1; break; end
        end
        check($sformatf("vec%0d finished", idx), 32'(fin), 32'd1);
        check($sformatf("vec%0d busy cycles", idx), 32'(busy_cnt), 32'd33);
        check($sformatf("vec%0d done pulses", idx), 32'(done_cnt), 32'd1);
        check($sformatf("vec%0d done cycle", idx), 32'(done_cyc), 32'd33);
        check($sformatf("vec%0d hi", idx), bus.hi, ehi);
        check($sformatf("vec%0d lo", idx), bus.lo, elo);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic last_stall;

        vecs[0]  = '{MDU_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3]  = '{MDU_MULT,  32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        vecs[4]  = '{MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[5]  = '{MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[6]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[7]  = '{MDU_DIV,   32'd7,        32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD};
        vecs[8]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
        vecs[9]  = '{MDU_DIVU,  32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF};
        vecs[10] = '{MDU_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[11] = '{MDU_DIVU,  32'hFFFF_FFFF, 32'd10,       32'd5,        32'h1999_9999};
        vecs[12] = '{MDU_DIV,   32'h8000_0000, 32'd2,        32'd0,        32'hC000_0000};

        // clock/reset
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 3'd0; bus.rs_value = '0; bus.rt_value = '0;
        bus.rd_req = 1'b0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset stall", 32'(bus.stall), 32'd0);

        // table-driven full operations
        for (int i = 0; i < 13; i++)
            run_op(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        bus.start = 1'b1; bus.op = MDU_MTHI; bus.rs_value = 32'hAAAA_5555;
        @(posedge clk); #1;
        bus.op = MDU_MTLO; bus.rs_value = 32'h0000_0001;
        @(negedge clk);
        check("mthi hi", bus.hi, 32'hAAAA_5555);
        check("mthi busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("mtlo lo", bus.lo, 32'h0000_0001);
        check("mtlo hi kept", bus.hi, 32'hAAAA_5555);
        check("mtlo busy", 32'(bus.busy), 32'd0);
        check("mtlo done", 32'(bus.done), 32'd0);

        // rd_req from cycle 5 of a MULTU
        @(negedge clk);
        bus.start = 1'b1; bus.op = MDU_MULTU; bus.rs_value = 32'hFFFF_FFFF; bus.rt_value = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bad = 0; last_stall = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            if (k == 5) bus.rd_req = 1'b1;
            @(negedge clk);
            if (k >= 5 && bus.stall !== (k <= 33)) bad++;
            last_stall = bus.stall;
            if (k < 34) begin @(posedge clk); #1; end
        end
        check("rd_req stall window errors", 32'(bad), 32'd0);
        check("rd_req stall cycle34", 32'(last_stall), 32'd0);
        check("rd_req hi", bus.hi, 32'hFFFF_FFFE);
        check("rd_req lo", bus.lo, 32'h0000_0001);
        bus.rd_req = 1'b0;

        // MTHI presented while busy: stalled, then accepted in the first IDLE cycle
        @(negedge clk);
        bus.start = 1'b1; bus.op = MDU_MULT; bus.rs_value = 32'd2; bus.rt_value = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bad = 0;
        for (int k = 1; k <= 34; k++) begin
            if (k == 3) begin bus.start = 1'b1; bus.op = MDU_MTHI; bus.rs_value = 32'h5A5A_5A5A; end
            @(negedge clk);
            if (k >= 3 && bus.stall !== (k <= 33)) bad++;
            if (k <= 33 && bus.hi !== 32'hFFFF_FFFE) bad++;
            if (k < 34) begin @(posedge clk); #1; end
        end
        check("mthi-busy stall/hold errors", 32'(bad), 32'd0);
        check("mthi-busy mult hi", bus.hi, 32'd0);
        check("mthi-busy mult lo", bus.lo, 32'd6);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("mthi-busy accepted hi", bus.hi, 32'h5A5A_5A5A);
        check("mthi-busy lo kept", bus.lo, 32'd6);
        check("mthi-busy busy", 32'(bus.busy), 32'd0);

        // flush in cycle 10 of a DIV
        @(negedge clk);
        bus.start = 1'b1; bus.op = MDU_DIV; bus.rs_value = 32'd100; bus.rt_value = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) bus.flush = 1'b1;
            @(posedge clk); #1;
        end
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush busy next cycle", 32'(bus.busy), 32'd0);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) bad++;
        end
        check("flush no done", 32'(bad), 32'd0);
        check("flush hi kept", bus.hi, 32'h5A5A_5A5A);
        check("flush lo kept", bus.lo, 32'd6);

        // async reset in cycle 20 of a MULT
        @(negedge clk);
        bus.start = 1'b1; bus.op = MDU_MULT; bus.rs_value = 32'd5; bus.rt_value = 32'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k < 20; k++) begin @(posedge clk); #1; end
        #1 rst = 1'b1;
        #1;
        check("async rst busy", 32'(bus.busy), 32'd0);
        check("async rst hi", bus.hi, 32'd0);
        check("async rst lo", bus.lo, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("after rst busy", 32'(bus.busy), 32'd0);

        // flush in IDLE discards start and MTHI; reserved op ignored
        bus.start = 1'b1; bus.op = MDU_MULT; bus.rs_value = 32'd3; bus.rt_value = 32'd4; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.op = MDU_MTHI; bus.rs_value = 32'h0000_0123;
        @(negedge clk);
        check("idle flush start busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.op = 3'b110; bus.rs_value = 32'hDEAD_BEEF;
        @(negedge clk);
        check("idle flush mthi hi", bus.hi, 32'd0);
        @(posedge clk); #1;
        bus.op = 3'b111;
        @(negedge clk);
        check("reserved op busy", 32'(bus.busy), 32'd0);
        check("reserved op hi", bus.hi, 32'd0);
        check("reserved op lo", bus.lo, 32'd0);
        bus.start = 1'b0;

        run_op(99, MDU_MULT, 32'd5, 32'd6, 32'd0, 32'd30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
